// File: rtl/lcd_mask_loader.sv
// rtl/lcd_mask_loader.sv - RLE mask byte stream decoder feeding the LCD mask port
module lcd_mask_loader #(
  parameter int MASK_WORDS = 57600,
  parameter int WR_SPACING = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        mask_data_wr,
  output logic [15:0] mask_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  localparam int SW = (WR_SPACING > 1) ? $clog2(WR_SPACING) : 1;

  typedef enum logic [2:0] {IDLE, TOK_LO, TOK_HI, DAT_LO, DAT_HI, EMIT, DONE, ERROR} state_t;

  state_t        state;
  logic          tok_run;
  logic          last_seen;
  logic [7:0]    tok_lo;
  logic [7:0]    dat_lo;
  logic [15:0]   remaining;
  logic [15:0]   value;
  logic [SW-1:0] gap;

  logic          xfer;
  logic          space_ok;
  logic          emit_now;
  logic          last_now;
  logic [15:0]   emit_word;
  logic [15:0]   rem_after;
  logic [15:0]   wc_next;

  assign in_ready = state inside {TOK_LO, TOK_HI, DAT_LO, DAT_HI};
  assign busy     = !(state inside {IDLE, DONE, ERROR});
  assign done     = (state == DONE);
  assign error    = (state == ERROR);

  // The DAT_HI byte can be written straight through so the strobe lands one cycle after it.
  assign xfer      = in_valid && in_ready;
  assign space_ok  = (gap == '0);
  assign emit_now  = space_ok && ((state == EMIT) || (state == DAT_HI && xfer));
  assign emit_word = (state == EMIT) ? value : {in_data, dat_lo};
  assign last_now  = last_seen || (xfer && in_last);
  assign rem_after = remaining - 16'd1;
  assign wc_next   = word_count + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tok_run      <= 1'b0;
      last_seen    <= 1'b0;
      tok_lo       <= 8'd0;
      dat_lo       <= 8'd0;
      remaining    <= 16'd0;
      value        <= 16'd0;
      gap          <= '0;
      mask_data_wr <= 1'b0;
      mask_data    <= 16'd0;
      word_count   <= 16'd0;
    end else if (start) begin
      state        <= TOK_LO;
      last_seen    <= 1'b0;
      remaining    <= 16'd0;
      gap          <= '0;
      mask_data_wr <= 1'b0;
      word_count   <= 16'd0;
    end else begin
      mask_data_wr <= 1'b0;
      if (gap != '0) gap <= gap - SW'(1);
      if (xfer && in_last) last_seen <= 1'b1;

      if (emit_now) begin
        mask_data    <= emit_word;
        value        <= emit_word;
        mask_data_wr <= 1'b1;
        word_count   <= wc_next;
        remaining    <= rem_after;
        gap          <= SW'(WR_SPACING - 1);
        if (wc_next == 16'(MASK_WORDS))
          state <= (rem_after == 16'd0 && last_now) ? DONE : ERROR;
        else if (rem_after == 16'd0)
          state <= last_now ? ERROR : TOK_LO;
        else if (tok_run)
          state <= EMIT;
        else
          state <= last_now ? ERROR : DAT_LO;
      end else begin
        case (state)
          TOK_LO: if (xfer) begin
            tok_lo <= in_data;
            state  <= in_last ? ERROR : TOK_HI;
          end
          TOK_HI: if (xfer) begin
            remaining <= {1'b0, in_data[6:0], tok_lo} + 16'd1;
            tok_run   <= in_data[7];
            state     <= in_last ? ERROR : DAT_LO;
          end
          DAT_LO: if (xfer) begin
            dat_lo <= in_data;
            state  <= in_last ? ERROR : DAT_HI;
          end
          DAT_HI: if (xfer) begin
            value <= {in_data, dat_lo};
            state <= EMIT;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_mask_loader.sv
// tb/tb_lcd_mask_loader.sv - randomized self-checking bench for lcd_mask_loader
module tb_lcd_mask_loader;

  localparam int MW = 4;
  localparam int SP = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_last = 1'b0;
  logic        in_ready, mask_data_wr, busy, done, error;
  logic [15:0] mask_data, word_count;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [15:0] got[$];
  int          got_cyc[$];
  logic        got_rdy[$];
  logic [15:0] exp_w[$];
  bit          exp_done;

  lcd_mask_loader #(.MASK_WORDS(MW), .WR_SPACING(SP)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mask_data_wr(mask_data_wr), .mask_data(mask_data),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (mask_data_wr) begin
      got.push_back(mask_data);
      got_cyc.push_back(cyc);
      got_rdy.push_back(in_ready);
    end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Decode the whole byte stream as tokens; an early return means the load ends in error.
  task automatic model(input logic [7:0] b[$]);
    int p, cnt;
    bit run, last;
    logic [15:0] tok, v;
    exp_w = {};
    exp_done = 1'b0;
    p = 0;
    v = 16'd0;
    last = 1'b0;
    forever begin
      if (p + 2 >= b.size()) return;
      tok = {b[p+1], b[p]};
      p += 2;
      cnt = int'(tok[14:0]) + 1;
      run = tok[15];
      for (int k = 0; k < cnt; k++) begin
        if (!run || k == 0) begin
          if (p + 1 >= b.size()) return;
          v = {b[p+1], b[p]};
          last = (p + 1 == b.size() - 1);
          p += 2;
        end
        exp_w.push_back(v);
        if (exp_w.size() == MW) begin
          exp_done = (k == cnt - 1) && last;
          return;
        end
        if (last && !run) return;
      end
      if (last) return;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b[$], input bit with_last, input int idle_pct);
    int idx, budget;
    bit xf;
    idx = 0;
    budget = 0;
    while (busy && idx < b.size() && budget < 4000) begin
      in_valid = ($urandom_range(99) >= idle_pct);
      in_data  = b[idx];
      in_last  = with_last && (idx == b.size() - 1);
      @(negedge clk);
      xf = in_valid && in_ready;
      @(posedge clk); #1;
      if (xf) idx++;
      budget++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("feed_bound", budget < 4000, 1);
  endtask

  task automatic run_load(input logic [7:0] b[$], input int idle_pct, input string tag);
    int base, budget;
    model(b);
    base = got.size();
    pulse_start();
    feed(b, 1'b1, idle_pct);
    budget = 0;
    while (busy && budget < 2000) begin
      @(posedge clk); #1;
      budget++;
    end
    check({tag, "_timeout"}, budget < 2000, 1);
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_nstrobes"}, got.size() - base, exp_w.size());
    for (int i = 0; i < exp_w.size() && base + i < got.size(); i++)
      check({tag, "_word"}, got[base+i], exp_w[i]);
    for (int i = base + 1; i < got.size(); i++)
      check({tag, "_spacing_ok"}, (got_cyc[i] - got_cyc[i-1]) >= SP, 1);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_error"}, error, !exp_done);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_word_count"}, word_count, exp_w.size());
  endtask

  initial begin
    logic [7:0] b[$];
    int base, n, words, target, cnt, budget;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_ready", in_ready, 0);
    check("rst_wr", mask_data_wr, 0);
    check("rst_data", mask_data, 0);
    check("rst_count", word_count, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    b = {8'h03, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
    run_load(b, 0, "literal4");
    run_load(b, 30, "literal4_gaps");

    base = got.size();
    b = {8'h03, 8'h80, 8'hCD, 8'hAB};
    run_load(b, 0, "run4");
    for (int i = base + 1; i < got.size(); i++)
      check("run4_exact_gap", got_cyc[i] - got_cyc[i-1], SP);
    for (int i = base; i < got.size(); i++)
      check("run4_ready_low", got_rdy[i], 0);

    b = {8'h03, 8'h00, 8'h11, 8'h11};
    run_load(b, 0, "underrun");

    b = {8'h07, 8'h80, 8'h55, 8'h55};
    run_load(b, 0, "overflow");

    b = {8'h00, 8'h00, 8'h12, 8'h34, 8'h02, 8'h80, 8'h56, 8'h78, 8'h00, 8'h00, 8'h9A};
    run_load(b, 10, "trailing");

    base = got.size();
    b = {8'h03, 8'h80, 8'hEF, 8'hBE};
    pulse_start();
    feed(b, 1'b0, 0);
    budget = 0;
    while (got.size() < base + 2 && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    check("restart_wait", budget < 200, 1);
    pulse_start();
    check("restart_count", word_count, 0);
    check("restart_ready", in_ready, 1);
    check("restart_busy", busy, 1);
    n = got.size();
    repeat (10) @(posedge clk);
    #1;
    check("restart_no_strobe", got.size(), n);
    b = {8'h03, 8'h00, 8'hA1, 8'hA1, 8'hB2, 8'hB2, 8'hC3, 8'hC3, 8'hD4, 8'hD4};
    run_load(b, 20, "after_restart");

    b = {8'h03, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22};
    pulse_start();
    feed(b, 1'b0, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", in_ready, 0);
    check("arst_wr", mask_data_wr, 0);
    check("arst_data", mask_data, 0);
    check("arst_count", word_count, 0);
    check("arst_done_err", {done, error}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("arst_ready_idle", in_ready, 0);

    for (int t = 0; t < 30; t++) begin
      b = {};
      words = 0;
      target = $urandom_range(5, 2);
      while (words < target) begin
        cnt = $urandom_range(3, 1);
        b.push_back(8'(cnt - 1));
        if ($urandom_range(1) == 1) begin
          b.push_back(8'h80);
          b.push_back(8'($urandom));
          b.push_back(8'($urandom));
        end else begin
          b.push_back(8'h00);
          repeat (cnt) begin
            b.push_back(8'($urandom));
            b.push_back(8'($urandom));
          end
        end
        words += cnt;
      end
      if ($urandom_range(3) == 0) begin
        n = $urandom_range(b.size(), 1);
        while (b.size() > n) void'(b.pop_back());
      end
      run_load(b, $urandom_range(40, 0), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
